jk_excitation_driver: RTL and testbench

//  Drives a bank of external JK flip-flops to a requested target state. Accepts a

---
 rtl/jk_pkg.sv | 26 ++
 rtl/jk_excite_bit.sv | 15 +
 rtl/jk_excitation_driver.sv | 123 ++++++++++++
 tb/tb_jk_excitation_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared FSM state type, reset constants and JK excitation function
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } jk_state_e;

    localparam jk_state_e RST_STATE = ST_IDLE;
    localparam logic      RST_JK    = 1'b0;

    // Returns {j,k} that moves a JK flop from q to t; xval fills don't-care inputs.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic xval);
        logic [1:0] jk;
        case ({q, t})
            2'b00:   jk = {1'b0, xval};
            2'b01:   jk = {1'b1, xval};
            2'b10:   jk = {xval, 1'b1};
            default: jk = {xval, 1'b0};
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// rtl/jk_excite_bit.sv - single-bit combinational JK excitation
module jk_excite_bit
    import jk_pkg::*;
#(
    parameter bit XVAL = 1'b0
) (
    input  logic q_i,
    input  logic t_i,
    output logic j_o,
    output logic k_o
);

    assign {j_o, k_o} = jk_excite(q_i, t_i, XVAL);

endmodule

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives an external JK flop bank to a target word with settle/verify/retry
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_RETRY = 2,
    parameter bit          XVAL      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    jk_state_e        state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] exc_j, exc_k;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        jk_excite_bit #(.XVAL(XVAL)) u_bit (
            .q_i (q_in[i]),
            .t_i (target_q[i]),
            .j_o (exc_j[i]),
            .k_o (exc_k[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        j_d      = {WIDTH{RST_JK}};
        k_d      = {WIDTH{RST_JK}};
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    target_d = in_target;
                    retry_d  = '0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Registered so the bank sees a clean one-cycle pulse.
                j_d      = exc_j;
                k_d      = exc_k;
                settle_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (q_in == target_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            target_q <= '0;
            retry_q  <= '0;
            settle_q <= '0;
            j_q      <= {WIDTH{RST_JK}};
            k_q      <= {WIDTH{RST_JK}};
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign j_out    = j_q;
    assign k_out    = k_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - directed self-checking bench with behavioural JK flop banks
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid0, in_valid1;
    logic [3:0] in_target0, in_target1;
    logic       in_ready0, in_ready1;
    logic [3:0] q0, q1;
    logic [3:0] j0, k0, j1, k1;
    logic       busy0, busy1, done0, done1, err0, err1;
    logic [3:0] stuck0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .XVAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_target(in_target0), .q_in(q0), .j_out(j0), .k_out(k0),
        .busy(busy0), .done(done0), .err(err0)
    );

    jk_excitation_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .XVAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_target(in_target1), .q_in(q1), .j_out(j1), .k_out(k1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // JK characteristic Q+ = J&~Q | ~K&Q; stuck0 pins selected bits of bank 0 low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= 4'b0000;
            q1 <= 4'b0000;
        end else begin
            q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck0;
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer0(input string tag, input logic [3:0] tgt, input logic [3:0] jexp, input logic [3:0] kexp);
        in_valid0  = 1'b1;
        in_target0 = tgt;
        tick();
        in_valid0 = 1'b0;
        check({tag, "_busy"}, busy0, 1);
        check({tag, "_ready"}, in_ready0, 0);
        tick();
        check({tag, "_j"}, j0, jexp);
        check({tag, "_k"}, k0, kexp);
        tick();
        check({tag, "_jk_off"}, {j0, k0}, 0);
        tick();
        check({tag, "_done"}, done0, 1);
        check({tag, "_err"}, err0, 0);
        check({tag, "_q"}, q0, tgt);
        tick();
        check({tag, "_done_pulse"}, done0, 0);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic seen;

        rst_n      = 1'b0;
        in_valid0  = 1'b0;
        in_valid1  = 1'b0;
        in_target0 = 4'b0000;
        in_target1 = 4'b0000;
        stuck0     = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done_err", {done0, err0}, 0);
        check("rst_jk", {j0, k0}, 0);

        // Clean transfer 0000 -> 1010
        xfer0("t1", 4'b1010, 4'b1010, 4'b0000);

        // XVAL=1 bank: 0000 -> 1111, then 1111 -> 0101
        in_valid1 = 1'b1; in_target1 = 4'b1111;
        tick();
        in_valid1 = 1'b0;
        tick();
        check("t2a_j", j1, 4'b1111);
        check("t2a_k", k1, 4'b1111);
        tick(); tick();
        check("t2a_done", done1, 1);
        check("t2a_q", q1, 4'b1111);
        in_valid1 = 1'b1; in_target1 = 4'b0101;
        tick();
        in_valid1 = 1'b0;
        tick();
        check("t2b_j", j1, 4'b1111);
        check("t2b_k", k1, 4'b1010);
        tick(); tick();
        check("t2b_done", done1, 1);
        check("t2b_err", err1, 0);
        check("t2b_q", q1, 4'b0101);

        // in_valid held during the transfer: next target taken only after done
        in_valid0 = 1'b1; in_target0 = 4'b0110;
        tick();
        in_target0 = 4'b1111;
        check("t4_ready_drive", in_ready0, 0);
        tick();
        check("t4_j", j0, 4'b0100);
        check("t4_k", k0, 4'b1000);
        check("t4_ready_wait", in_ready0, 0);
        tick();
        check("t4_busy_check", busy0, 1);
        tick();
        check("t4_done", done0, 1);
        check("t4_q", q0, 4'b0110);
        check("t4_ready_idle", in_ready0, 1);
        tick();
        in_valid0 = 1'b0;
        check("t4_reaccept", busy0, 1);
        tick();
        check("t4_j2", j0, 4'b1001);
        check("t4_k2", k0, 4'b0000);
        tick(); tick();
        check("t4_done2", done0, 1);
        check("t4_q2", q0, 4'b1111);
        tick();

        // Back to 0110, then request the present state
        xfer0("t6pre", 4'b0110, 4'b0000, 4'b1001);
        xfer0("t6", 4'b0110, 4'b0000, 4'b0000);

        // Bit 0 stuck low: three drive pulses then err
        stuck0 = 4'b0001;
        in_valid0 = 1'b1; in_target0 = 4'b0001;
        tick();
        in_valid0 = 1'b0;
        cyc = 0; pulses = 0; seen = 1'b0;
        while (!err0 && cyc < 40) begin
            if ((j0 | k0) != 4'b0000) pulses++;
            if (done0) seen = 1'b1;
            tick();
            cyc++;
        end
        check("t3_err", err0, 1);
        check("t3_err_cycle", cyc, 9);
        check("t3_pulses", pulses, 3);
        check("t3_no_done", {seen, done0}, 0);
        check("t3_ready", in_ready0, 1);
        tick();
        check("t3_err_pulse", err0, 0);
        stuck0 = 4'b0000;

        // Reset while the drive pulse is out
        in_valid0 = 1'b1; in_target0 = 4'b1111;
        tick();
        in_valid0 = 1'b0;
        tick();
        check("t5_pulse", j0, 4'b1111);
        rst_n = 1'b0;
        #1;
        check("t5_jk_zero", {j0, k0}, 0);
        check("t5_busy", busy0, 0);
        check("t5_done_err", {done0, err0}, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done0 || err0) seen = 1'b1;
        end
        check("t5_no_pulse", seen, 0);
        check("t5_ready", in_ready0, 1);
        check("t5_idle_jk", {j0, k0}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
